// File: rtl/fifo_pkg.sv
// fifo_pkg: shared helpers for the fifo_hs channel buffer.
//   clog2   - ceiling log2 used to size pointers and the occupancy counter.
//   ptr_inc - pointer increment that wraps at an arbitrary depth, so depths
//             that are not powers of two never alias onto unused slots.
package fifo_pkg;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

    function automatic int unsigned ptr_inc(input int unsigned ptr, input int unsigned depth);
        return (ptr == depth - 1) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/fifo_mem.sv
// fifo_mem: DATA_WIDTH x FIFO_DEPTH storage with synchronous write and
// asynchronous read, kept separate so it can map onto distributed RAM.
// The array has no reset; control logic decides which entries are valid.
// Ports:
//   clk   - write clock
//   we    - write enable
//   waddr - write address
//   wdata - write data
//   raddr - read address
//   rdata - read data, combinational from raddr
module fifo_mem #(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/fifo_hs.sv
// fifo_hs: synchronous valid/ready FIFO with first-word-fall-through output,
// arbitrary depth, exact occupancy count, almost-full/almost-empty flags and
// synchronous flush.
//
// Handshake: a word is written when s_valid_i & s_ready_o at a rising edge and
// consumed when m_valid_o & m_ready_i at a rising edge. Every output is a
// decode of registered state, so s_ready_o never depends on s_valid_i and
// m_* never depends on s_* within a cycle. While full, a pop in the same
// cycle does not open room for a push; s_ready_o rises the following cycle.
//
// Ports:
//   clk, rst_n           - clock, synchronous active-low reset (wins over flush)
//   flush_i              - synchronous clear of all entries
//   s_data_i/valid/ready - producer side
//   m_data_o/valid/ready - consumer side (m_data_o is the head entry)
//   count_o              - occupancy 0..FIFO_DEPTH
//   empty_o, full_o, almost_empty_o, almost_full_o - decodes of count_o
module fifo_hs
    import fifo_pkg::*;
#(
    parameter  int DATA_WIDTH = 8,
    parameter  int FIFO_DEPTH = 32,
    parameter  int AF_LEVEL   = FIFO_DEPTH - 1,
    parameter  int AE_LEVEL   = 1,
    localparam int ADDR_WIDTH = (clog2(FIFO_DEPTH) < 1) ? 1 : clog2(FIFO_DEPTH),
    localparam int CNT_WIDTH  = clog2(FIFO_DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush_i,
    input  logic [DATA_WIDTH-1:0] s_data_i,
    input  logic                  s_valid_i,
    output logic                  s_ready_o,
    output logic [DATA_WIDTH-1:0] m_data_o,
    output logic                  m_valid_o,
    input  logic                  m_ready_i,
    output logic [CNT_WIDTH-1:0]  count_o,
    output logic                  empty_o,
    output logic                  full_o,
    output logic                  almost_empty_o,
    output logic                  almost_full_o
);

    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [CNT_WIDTH-1:0]  count;
    logic                  push;
    logic                  pop;

    // Flags decode the count register directly.
    assign empty_o        = (count == '0);
    assign full_o         = (count == CNT_WIDTH'(FIFO_DEPTH));
    assign almost_empty_o = (count <= CNT_WIDTH'(AE_LEVEL));
    assign almost_full_o  = (count >= CNT_WIDTH'(AF_LEVEL));
    assign count_o        = count;
    assign s_ready_o      = !full_o;
    assign m_valid_o      = !empty_o;

    assign push = s_valid_i && s_ready_o;
    assign pop  = m_valid_o && m_ready_i;

    always_ff @(posedge clk) begin
        if (!rst_n || flush_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= ADDR_WIDTH'(ptr_inc(32'(wr_ptr), 32'(FIFO_DEPTH)));
            end
            if (pop) begin
                rd_ptr <= ADDR_WIDTH'(ptr_inc(32'(rd_ptr), 32'(FIFO_DEPTH)));
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_WIDTH'(1);
                2'b01:   count <= count - CNT_WIDTH'(1);
                default: count <= count;
            endcase
        end
    end

    // A push in a reset or flush cycle must not land in storage either, so
    // the write enable is qualified the same way the pointer move is.
    fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_mem (
        .clk   (clk),
        .we    (push && rst_n && !flush_i),
        .waddr (wr_ptr),
        .wdata (s_data_i),
        .raddr (rd_ptr),
        .rdata (m_data_o)
    );

endmodule

// File: tb/tb_fifo_hs.sv
// Bench for fifo_hs at DEPTH=5, DATA_WIDTH=8, AF_LEVEL=4, AE_LEVEL=1.
// A queue model follows the handshake rules at each rising edge; a compare
// process checks every output against it on each falling edge. Directed
// literal checks pin the model at points the test plan calls out.
module tb_fifo_hs;

    localparam int DW    = 8;
    localparam int DEPTH = 5;
    localparam int AF    = 4;
    localparam int AE    = 1;

    logic          clk;
    logic          rst_n;
    logic          flush;
    logic [DW-1:0] s_data;
    logic          s_valid;
    logic          s_ready;
    logic [DW-1:0] m_data;
    logic          m_valid;
    logic          m_ready;
    logic [2:0]    count;
    logic          empty;
    logic          full;
    logic          almost_empty;
    logic          almost_full;

    int checks;
    int failures;

    logic [DW-1:0] exp_q[$];
    bit            model_on;

    fifo_hs #(
        .DATA_WIDTH (DW),
        .FIFO_DEPTH (DEPTH),
        .AF_LEVEL   (AF),
        .AE_LEVEL   (AE)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .flush_i        (flush),
        .s_data_i       (s_data),
        .s_valid_i      (s_valid),
        .s_ready_o      (s_ready),
        .m_data_o       (m_data),
        .m_valid_o      (m_valid),
        .m_ready_i      (m_ready),
        .count_o        (count),
        .empty_o        (empty),
        .full_o         (full),
        .almost_empty_o (almost_empty),
        .almost_full_o  (almost_full)
    );

    // Clock and reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: the FIFO is an ordered queue of at most DEPTH words.
    always @(posedge clk) begin
        bit do_push;
        bit do_pop;
        if (!rst_n) begin
            exp_q.delete();
            model_on = 1'b1;
        end else if (flush) begin
            exp_q.delete();
        end else begin
            do_push = s_valid && (exp_q.size() < DEPTH);
            do_pop  = m_ready && (exp_q.size() > 0);
            if (do_pop) begin
                void'(exp_q.pop_front());
            end
            if (do_push) begin
                exp_q.push_back(s_data);
            end
        end
    end

    // Compare process
    always @(negedge clk) begin
        int n;
        if (model_on) begin
            n = exp_q.size();
            check("cmp_count", 32'(count), 32'(n));
            check("cmp_empty", 32'(empty), 32'(n == 0));
            check("cmp_full", 32'(full), 32'(n == DEPTH));
            check("cmp_s_ready", 32'(s_ready), 32'(n != DEPTH));
            check("cmp_m_valid", 32'(m_valid), 32'(n != 0));
            check("cmp_almost_empty", 32'(almost_empty), 32'(n <= AE));
            check("cmp_almost_full", 32'(almost_full), 32'(n >= AF));
            if (n > 0) begin
                check("cmp_m_data", 32'(m_data), 32'(exp_q[0]));
            end
        end
    end

    // Driver: apply inputs, take one rising edge, return 1 time unit after it.
    task automatic cycle(input bit sv, input logic [DW-1:0] sd, input bit mr,
                         input bit fl, input bit rn);
        s_valid = sv;
        s_data  = sd;
        m_ready = mr;
        flush   = fl;
        rst_n   = rn;
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [DW-1:0] d);
        cycle(1'b1, d, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic idle();
        cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        model_on = 1'b0;
        s_valid  = 1'b0;
        s_data   = '0;
        m_ready  = 1'b0;
        flush    = 1'b0;
        rst_n    = 1'b0;

        cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        idle();
        check("rst_count", 32'(count), 32'd0);
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_s_ready", 32'(s_ready), 32'd1);
        check("rst_m_valid", 32'(m_valid), 32'd0);
        check("rst_almost_empty", 32'(almost_empty), 32'd1);
        check("rst_almost_full", 32'(almost_full), 32'd0);

        // Fill to full, overflow attempt, drain in order.
        for (int i = 0; i < 5; i++) begin
            push(8'h11 + 8'(i));
        end
        check("fill_count", 32'(count), 32'd5);
        check("fill_full", 32'(full), 32'd1);
        check("fill_s_ready", 32'(s_ready), 32'd0);
        check("fill_almost_full", 32'(almost_full), 32'd1);
        push(8'h16);
        check("ovf_count", 32'(count), 32'd5);
        check("ovf_head", 32'(m_data), 32'h11);
        for (int i = 0; i < 5; i++) begin
            check("drain_data", 32'(m_data), 32'(8'h11 + 8'(i)));
            cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
        end
        check("drain_empty", 32'(empty), 32'd1);
        check("drain_no_dup", 32'(m_valid), 32'd0);

        // Interleaved traffic; the write pointer wraps past index 4 twice.
        for (int i = 0; i < 12; i++) begin
            cycle(1'b1, 8'h20 + 8'(i), (i >= 2), 1'b0, 1'b1);
        end
        check("ilv_count", 32'(count), 32'd2);
        check("ilv_head", 32'(m_data), 32'h2a);
        for (int i = 0; i < 2; i++) begin
            cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
        end
        check("ilv_empty", 32'(empty), 32'd1);

        // FWFT latency from empty.
        push(8'ha5);
        check("fwft_valid", 32'(m_valid), 32'd1);
        check("fwft_data", 32'(m_data), 32'ha5);
        check("fwft_count", 32'(count), 32'd1);
        check("fwft_empty", 32'(empty), 32'd0);
        check("fwft_almost_empty", 32'(almost_empty), 32'd1);

        // Simultaneous push and pop at count 3.
        push(8'hb0);
        push(8'hb1);
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, 8'hc0 + 8'(i), 1'b1, 1'b0, 1'b1);
            check("pp_count", 32'(count), 32'd3);
        end
        check("pp_head", 32'(m_data), 32'hc1);
        push(8'hd0);
        push(8'hd1);
        check("pp_full", 32'(full), 32'd1);
        cycle(1'b1, 8'he0, 1'b1, 1'b0, 1'b1);
        check("full_pp_count", 32'(count), 32'd4);
        check("full_pp_s_ready", 32'(s_ready), 32'd1);
        check("full_pp_head", 32'(m_data), 32'hc2);

        // Flush with a concurrent push: the push is dropped.
        cycle(1'b1, 8'hee, 1'b0, 1'b1, 1'b1);
        check("flush_count", 32'(count), 32'd0);
        check("flush_empty", 32'(empty), 32'd1);
        check("flush_m_valid", 32'(m_valid), 32'd0);
        idle();
        check("flush_stays_empty", 32'(count), 32'd0);

        // Reset mid-stream together with flush and a push.
        push(8'h31);
        push(8'h32);
        push(8'h33);
        check("pre_rst_count", 32'(count), 32'd3);
        cycle(1'b1, 8'h34, 1'b1, 1'b1, 1'b0);
        check("mid_rst_count", 32'(count), 32'd0);
        check("mid_rst_m_valid", 32'(m_valid), 32'd0);
        check("mid_rst_s_ready", 32'(s_ready), 32'd1);
        check("mid_rst_almost_full", 32'(almost_full), 32'd0);
        push(8'h3c);
        check("post_rst_head", 32'(m_data), 32'h3c);
        check("post_rst_count", 32'(count), 32'd1);
        idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
